// File: rtl/risc_fetch_queue_pkg.sv
// Shared types and width helpers for the RISC8 fetch queue.
package risc_fetch_queue_pkg;
  typedef enum logic [1:0] {RUN, FLUSH, ALIGN} fetch_state_t;

  function automatic int bpw_of(int rom_width);
    return rom_width / 8;
  endfunction

  function automatic int w1(int n);
    return (n < 1) ? 1 : n;
  endfunction
endpackage

// File: rtl/risc_fetch_queue_if.sv
// ROM and decoder-side bus of the fetch queue; master = fetch unit.
interface risc_fetch_queue_if #(
  parameter int ROM_WIDTH       = 32,
  parameter int ADDR_WIDTH      = 16,
  parameter int MAX_INSTR_BYTES = 4
);
  import risc_fetch_queue_pkg::*;
  localparam int WW = ADDR_WIDTH - $clog2(bpw_of(ROM_WIDTH));
  localparam int LW = $clog2(MAX_INSTR_BYTES + 1);

  logic                         rom_en;
  logic [WW-1:0]                rom_addr;
  logic [ROM_WIDTH-1:0]         rom_data;
  logic                         redirect;
  logic [ADDR_WIDTH-1:0]        redirect_pc;
  logic [8*MAX_INSTR_BYTES-1:0] instr;
  logic [ADDR_WIDTH-1:0]        instr_pc;
  logic [LW-1:0]                instr_len;
  logic                         instr_valid;
  logic                         instr_ready;

  modport master (
    output rom_en, rom_addr, instr, instr_pc, instr_valid,
    input  rom_data, redirect, redirect_pc, instr_len, instr_ready
  );
  modport slave (
    input  rom_en, rom_addr, instr, instr_pc, instr_valid,
    output rom_data, redirect, redirect_pc, instr_len, instr_ready
  );
endinterface

// File: rtl/risc_fetch_queue_fetch_byte_queue.sv
// Circular byte buffer: up to BPW bytes pushed and up to MAX_INSTR_BYTES popped per cycle.
module fetch_byte_queue #(
  parameter int QUEUE_BYTES     = 8,
  parameter int BPW             = 4,
  parameter int MAX_INSTR_BYTES = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic [BPW-1:0][7:0]                   push_data,
  input  logic [$clog2(BPW+1)-1:0]              push_cnt,
  input  logic [$clog2(MAX_INSTR_BYTES+1)-1:0]  pop_cnt,
  output logic [$clog2(QUEUE_BYTES):0]          count,
  output logic [MAX_INSTR_BYTES-1:0][7:0]       head
);
  localparam int PW = $clog2(QUEUE_BYTES);
  localparam int CW = PW + 1;

  logic [QUEUE_BYTES-1:0][7:0] mem;
  logic [PW-1:0]               rd_ptr, wr_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_cnt);
      rd_ptr <= rd_ptr + PW'(pop_cnt);
      count  <= count + CW'(push_cnt) - CW'(pop_cnt);
    end
  end

  // Storage is never cleared; only bytes below count are ever exposed.
  always_ff @(posedge clk)
    for (int j = 0; j < BPW; j++)
      if (!flush && j < int'(push_cnt)) mem[wr_ptr + PW'(j)] <= push_data[j];

  for (genvar i = 0; i < MAX_INSTR_BYTES; i++) begin : g_head
    assign head[i] = (CW'(i) < count) ? mem[rd_ptr + PW'(i)] : 8'h00;
  end
endmodule

// File: rtl/risc_fetch_queue.sv
// RISC8 fetch unit: ROM word prefetch into a byte queue, variable-length instruction head, redirects.
// Optional RISC_FETCH_PERF_EN adds stall/redirect performance counters.  Assumes BPW >= 2.
module risc_fetch_queue
  import risc_fetch_queue_pkg::*;
#(
  parameter int ROM_WIDTH       = 32,
  parameter int ADDR_WIDTH      = 16,
  parameter int QUEUE_BYTES     = 8,
  parameter int MAX_INSTR_BYTES = 4
) (
  input  logic               clk,
  input  logic               rst,
`ifdef RISC_FETCH_PERF_EN
  output logic [31:0]        perf_stall_cycles,
  output logic [31:0]        perf_redirects,
`endif
  risc_fetch_queue_if.master bus
);
  localparam int BPW = bpw_of(ROM_WIDTH);
  localparam int BW  = $clog2(BPW);
  localparam int SW  = w1(BW);
  localparam int WW  = ADDR_WIDTH - BW;
  localparam int LW  = $clog2(MAX_INSTR_BYTES + 1);
  localparam int PCW = $clog2(BPW + 1);
  localparam int CW  = $clog2(QUEUE_BYTES) + 1;

  fetch_state_t                       state;
  logic                               inflight, kill, fire, issue;
  logic [WW-1:0]                      fetch_word;
  logic [SW-1:0]                      skip, skip_now;
  logic [ADDR_WIDTH-1:0]              pc;
  logic [CW-1:0]                      count;
  logic [LW-1:0]                      pop_cnt;
  logic [PCW-1:0]                     push_cnt;
  logic [BPW-1:0][7:0]                push_data;
  logic [MAX_INSTR_BYTES-1:0][7:0]    head;

  assign bus.instr       = head;
  assign bus.instr_pc    = pc;
  assign bus.instr_valid = (bus.instr_len != '0) && (count >= CW'(bus.instr_len));
  assign bus.rom_en      = issue;
  assign bus.rom_addr    = fetch_word;

  // Space check counts bytes freed by this cycle's pop and bytes landing from the word in flight.
  always_comb begin
    fire      = bus.instr_valid && bus.instr_ready && !bus.redirect;
    pop_cnt   = fire ? bus.instr_len : '0;
    skip_now  = (state == ALIGN) ? skip : '0;
    push_cnt  = (inflight && !kill && !bus.redirect) ? PCW'(BPW) - PCW'(skip_now) : '0;
    push_data = bus.rom_data >> {skip_now, 3'b000};
    issue     = !rst && !bus.redirect &&
                (int'(count) - int'(pop_cnt) + ((inflight && !kill) ? BPW : 0) <= QUEUE_BYTES - BPW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      inflight   <= 1'b0;
      kill       <= 1'b0;
      fetch_word <= '0;
      skip       <= '0;
      pc         <= '0;
    end else begin
      inflight <= issue;
      kill     <= bus.redirect;
      if (bus.redirect) begin
        state      <= FLUSH;
        pc         <= bus.redirect_pc;
        fetch_word <= bus.redirect_pc[ADDR_WIDTH-1:BW];
        skip       <= bus.redirect_pc[BW-1:0];
      end else begin
        if (issue) fetch_word <= fetch_word + WW'(1);
        if (fire)  pc <= pc + ADDR_WIDTH'(bus.instr_len);
        case (state)
          FLUSH:   if (issue) state <= ALIGN;
          ALIGN:   if (inflight) state <= RUN;
          default: state <= RUN;
        endcase
      end
    end
  end

  fetch_byte_queue #(
    .QUEUE_BYTES(QUEUE_BYTES), .BPW(BPW), .MAX_INSTR_BYTES(MAX_INSTR_BYTES)
  ) u_queue (
    .clk(clk), .rst(rst), .flush(bus.redirect),
    .push_data(push_data), .push_cnt(push_cnt), .pop_cnt(pop_cnt),
    .count(count), .head(head)
  );

`ifdef RISC_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_redirects    <= '0;
    end else begin
      if (bus.instr_ready && !bus.instr_valid && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (bus.redirect && perf_redirects != '1)
        perf_redirects <= perf_redirects + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_risc_fetch_queue.sv
// Scoreboard bench: expected instruction stream derived from ROM bytes and the length decode rule.
module tb_risc_fetch_queue;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   len_mode;
  logic [7:0] rom_mem [0:65535];

  typedef struct {
    logic [15:0] pc;
    int          len;
    logic [31:0] bytes;
  } exp_t;
  exp_t exp_q[$];

  risc_fetch_queue_if bus ();
`ifdef RISC_FETCH_PERF_EN
  logic [31:0] perf_stall_cycles, perf_redirects;
`endif

  risc_fetch_queue dut (
    .clk(clk),
    .rst(rst),
`ifdef RISC_FETCH_PERF_EN
    .perf_stall_cycles(perf_stall_cycles),
    .perf_redirects(perf_redirects),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [13:0] wa);
    logic [31:0] w;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = rom_mem[{wa, 2'(b)}];
    return w;
  endfunction

  always @(posedge clk)
    if (bus.rom_en) bus.rom_data <= rom_word(bus.rom_addr);

  // Instruction length decode: mode 0 all 1-byte, mode 1 opcode[1:0]+1, mode 2 undecodable (0).
  always_comb begin
    bus.instr_len = 3'd1;
    if (len_mode == 1)      bus.instr_len = 3'(bus.instr[1:0]) + 3'd1;
    else if (len_mode == 2) bus.instr_len = 3'd0;
  end

  function automatic int len_model(input logic [7:0] op);
    if (len_mode == 1) return int'(op[1:0]) + 1;
    return 1;
  endfunction

  task automatic restart_exp(input logic [15:0] pc);
    exp_t e;
    logic [15:0] p = pc;
    exp_q.delete();
    for (int k = 0; k < 300; k++) begin
      e.pc = p; e.len = len_model(rom_mem[p]); e.bytes = '0;
      for (int b = 0; b < e.len; b++) e.bytes[8*b +: 8] = rom_mem[16'(p + 16'(b))];
      exp_q.push_back(e);
      p = p + 16'(e.len);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    logic [31:0] act;
    if (!rst && !bus.redirect && bus.instr_valid && bus.instr_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_empty got_pc=%h want=none", bus.instr_pc);
      end else begin
        e = exp_q.pop_front();
        act = '0;
        for (int b = 0; b < 4; b++) if (b < e.len) act[8*b +: 8] = bus.instr[8*b +: 8];
        chk("sb_pc", 32'(bus.instr_pc), 32'(e.pc));
        chk("sb_bytes", act, e.bytes);
      end
    end
  end

  task automatic do_reset(input int mode);
    rst = 1'b1; bus.redirect = 1'b0; len_mode = mode;
    repeat (2) @(posedge clk);
    #1;
    restart_exp(16'h0000);
    rst = 1'b0;
  endtask

  // Called at posedge+1; holds redirect for exactly one cycle.
  task automatic do_redirect(input logic [15:0] pc);
    bus.redirect = 1'b1; bus.redirect_pc = pc;
    restart_exp(pc);
    @(posedge clk); #1;
    bus.redirect = 1'b0;
  endtask

  task automatic expect_head(input string nm, input logic [15:0] pc);
    int n = 0;
    @(negedge clk);
    while (!bus.instr_valid && n < 20) begin @(negedge clk); n++; end
    chk({nm, "_valid"}, 32'(bus.instr_valid), 32'd1);
    chk({nm, "_pc"}, 32'(bus.instr_pc), 32'(pc));
    chk({nm, "_op"}, 32'(bus.instr[7:0]), 32'(rom_mem[pc]));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bubbles;
    int p, k;
    rst = 1'b1; bus.redirect = 1'b0; bus.redirect_pc = '0; bus.instr_ready = 1'b0; len_mode = 0;
    for (int a = 0; a < 65536; a++) rom_mem[a] = 8'(a);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus.instr_valid), 0);
    chk("rst_pc", 32'(bus.instr_pc), 0);
    chk("rst_rom_en", 32'(bus.rom_en), 0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 0);
    chk("rst_instr", bus.instr, 0);
    @(posedge clk); #1;
    restart_exp(16'h0000);
    rst = 1'b0; bus.instr_ready = 1'b1;
    @(negedge clk);
    chk("first_rom_en", 32'(bus.rom_en), 1);

    // straight-line, one instruction per cycle after fill
    repeat (5) @(negedge clk);
    bubbles = 0;
    repeat (50) begin @(negedge clk); if (!bus.instr_valid) bubbles++; end
    chk("straight_bubbles", 32'(bubbles), 0);

    // back-pressure
    @(posedge clk); #1; bus.instr_ready = 1'b0;
    repeat (20) @(negedge clk);
    chk("bp_rom_en", 32'(bus.rom_en), 0);
    chk("bp_valid", 32'(bus.instr_valid), 1);
    @(posedge clk); #1; len_mode = 2;
    @(negedge clk);
    chk("len0_valid", 32'(bus.instr_valid), 0);
    @(posedge clk); #1; len_mode = 0; bus.instr_ready = 1'b1;
    repeat (40) @(posedge clk);

    // mixed lengths 1,2,3,4 repeating
    #1; rst = 1'b1;
    for (int a = 0; a < 65536; a++) rom_mem[a] = 8'($urandom);
    p = 0; k = 0;
    while (p < 2048) begin
      rom_mem[p][1:0] = 2'(k % 4);
      p += (k % 4) + 1; k++;
    end
    do_reset(1);
    repeat (100) @(posedge clk);

    // random ready and random redirects, including back-to-back
    #1;
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(1, 25)) begin
        bus.instr_ready = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
      end
      do_redirect(16'($urandom));
      if ($urandom_range(0, 3) == 0) do_redirect(16'($urandom));
    end
    bus.instr_ready = 1'b1;
    repeat (30) @(posedge clk);

    // redirect while a response is in flight
    #1; rst = 1'b1;
    for (int a = 0; a < 65536; a++) rom_mem[a] = 8'(a);
    do_reset(0);
    begin
      int n = 0;
      @(negedge clk);
      while (!bus.rom_en && n < 10) begin @(negedge clk); n++; end
      chk("inflight_rom_en", 32'(bus.rom_en), 1);
    end
    @(posedge clk); #1;
    do_redirect(16'h0013);
    expect_head("redir13", 16'h0013);

    // redirect alongside a handshake, then back-to-back
    repeat (5) @(posedge clk);
    #1;
    do_redirect(16'h0100);
    do_redirect(16'h0200);
    do_redirect(16'h02A1);
    expect_head("b2b", 16'h02A1);

    // PC wrap
    repeat (3) @(posedge clk);
    #1;
    do_redirect(16'hFFFE);
    expect_head("wrap", 16'hFFFE);
    repeat (10) @(posedge clk);

    // reset mid-fill
    #1; bus.instr_ready = 1'b0;
    do_redirect(16'h0040);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", 32'(bus.instr_valid), 0);
    chk("midrst_pc", 32'(bus.instr_pc), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
